ram_init_port: RTL and testbench

RAM_INIT_PORT -- requirements
Module: ram_init_port

---
 rtl/ram_init_pkg.sv | 18 +
 rtl/ram_rsp_fifo.sv | 66 ++++++
 rtl/ram_init_port.sv | 186 ++++++++++++++++++
 tb/tb_ram_init_port.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_init_pkg.sv
// Shared types and helpers for the RAM initiator block.
package ram_init_pkg;

    // Init sequencer states: CLEAR sweeps the RAM with zeros, RUN serves commands.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } init_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO; head is registered storage, occupancy is exported
// so the parent can budget read credit.
module ram_rsp_fifo
    import ram_init_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Popping an empty FIFO is ignored; the parent's credit scheme keeps pushes legal.
    assign do_pop = pop_i && (count_q != '0);

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !do_pop) count_d = count_q + CW'(1);
        if (!push_i && do_pop) count_d = count_q - CW'(1);
    end

    // Control state, cleared by reset so buffered responses are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ram_init_port.sv
// Initiator side of a single-port byte-masked RAM: registers commands onto the
// RAM port, captures read data after READ_LATENCY cycles and returns it in order
// through a credit-limited response FIFO.
// Optional feature macro RAM_INIT_ZEROIZE_EN: after reset, write zeros to every
// word before accepting commands.
module ram_init_port
    import ram_init_pkg::*;
#(
    parameter int WORD_COUNT   = 1024,
    parameter int WORD_WIDTH   = 32,
    parameter int MASK_WIDTH   = 4,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4,
    localparam int AW          = clog2(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [AW-1:0]         cmd_addr,
    input  logic [MASK_WIDTH-1:0] cmd_mask,
    input  logic [WORD_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_data,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [AW-1:0]         ram_addr,
    output logic [MASK_WIDTH-1:0] ram_mask,
    output logic [WORD_WIDTH-1:0] ram_wrData,
    input  logic [WORD_WIDTH-1:0] ram_rdData,
    output logic                  init_done
);

    localparam int OCW  = clog2(RSP_DEPTH + 1);
    localparam int OUTW = clog2(RSP_DEPTH + READ_LATENCY + 2);

    logic                    ram_en_q, ram_en_d;
    logic                    ram_wr_q, ram_wr_d;
    logic [AW-1:0]           ram_addr_q, ram_addr_d;
    logic [MASK_WIDTH-1:0]   ram_mask_q, ram_mask_d;
    logic [WORD_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    init_done_q;
    logic [READ_LATENCY-1:0] rd_pipe_q;

    logic                    rd_pres;
    logic                    wr_block;
    logic                    rd_credit;
    logic                    cmd_fire;
    logic [OUTW-1:0]         outstanding;
    logic [OCW-1:0]          fifo_count;
    logic                    clr_issue;
    logic [AW-1:0]           clr_addr;
    logic                    fsm_run;

`ifdef RAM_INIT_ZEROIZE_EN
    init_state_e   state_q, state_d;
    logic [AW-1:0] clr_q, clr_d;

    // Sequencer state and clear address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Sweep 0..WORD_COUNT-1 once, then park in RUN.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            CLEAR: begin
                if (clr_q == AW'(WORD_COUNT - 1)) begin
                    clr_d   = '0;
                    state_d = RUN;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Sequencer outputs.
    always_comb begin
        clr_issue = (state_q == CLEAR);
        clr_addr  = clr_q;
        fsm_run   = (state_q == RUN);
    end
`else
    assign clr_issue = 1'b0;
    assign clr_addr  = '0;
    assign fsm_run   = 1'b1;
`endif

    // A read is on the RAM port this cycle.
    assign rd_pres = ram_en_q && !ram_wr_q;

    // With a two-cycle RAM, a write right behind a read would clobber its output register.
    assign wr_block = (READ_LATENCY == 2) && rd_pres;

    // Reads owed to the consumer: on the port, in the latency pipe, or buffered.
    always_comb begin
        outstanding = OUTW'(fifo_count) + OUTW'(rd_pres);
        for (int i = 0; i < READ_LATENCY; i++)
            outstanding = outstanding + OUTW'(rd_pipe_q[i]);
    end

    assign rd_credit = (outstanding < OUTW'(RSP_DEPTH));
    assign cmd_ready = init_done_q && (cmd_wr ? !wr_block : rd_credit);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // RAM port next state: clear writes, then accepted commands; idle cycles hold the data path.
    always_comb begin
        ram_en_d    = 1'b0;
        ram_wr_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_mask_d  = ram_mask_q;
        ram_wdata_d = ram_wdata_q;
        if (clr_issue) begin
            ram_en_d    = 1'b1;
            ram_wr_d    = 1'b1;
            ram_addr_d  = clr_addr;
            ram_mask_d  = '1;
            ram_wdata_d = '0;
        end else if (cmd_fire) begin
            ram_en_d   = 1'b1;
            ram_wr_d   = cmd_wr;
            ram_addr_d = cmd_addr;
            if (cmd_wr) begin
                ram_mask_d  = cmd_mask;
                ram_wdata_d = cmd_data;
            end
        end
    end

    // RAM port registers, init flag and read-latency valid pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_mask_q  <= '0;
            ram_wdata_q <= '0;
            init_done_q <= 1'b0;
            rd_pipe_q   <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_mask_q  <= ram_mask_d;
            ram_wdata_q <= ram_wdata_d;
            init_done_q <= fsm_run;
            rd_pipe_q[0] <= rd_pres;
            for (int i = 1; i < READ_LATENCY; i++)
                rd_pipe_q[i] <= rd_pipe_q[i-1];
        end
    end

    ram_rsp_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rd_pipe_q[READ_LATENCY-1]),
        .push_data_i (ram_rdData),
        .pop_i       (rsp_ready),
        .valid_o     (rsp_valid),
        .data_o      (rsp_data),
        .count_o     (fifo_count)
    );

    assign ram_en     = ram_en_q;
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_mask   = ram_mask_q;
    assign ram_wrData = ram_wdata_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_ram_init_port.sv
// Directed bench for ram_init_port with a behavioural byte-masked RAM model.
module tb_ram_init_port;

    localparam int WC = 16;
    localparam int AW = 4;
    localparam int L  = 2;
    localparam int RD = 4;
`ifdef RAM_INIT_ZEROIZE_EN
    localparam int INIT_EDGE = WC + 1;
    localparam int NCLR      = WC;
`else
    localparam int INIT_EDGE = 1;
    localparam int NCLR      = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [3:0]    cmd_mask = '0;
    logic [31:0]   cmd_data = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_mask;
    logic [31:0]   ram_wrData, ram_rdData;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_init_port #(
        .WORD_COUNT(WC), .WORD_WIDTH(32), .MASK_WIDTH(4),
        .READ_LATENCY(L), .RSP_DEPTH(RD)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_mask(ram_mask),
        .ram_wrData(ram_wrData), .ram_rdData(ram_rdData), .init_done(init_done)
    );

    // RAM model: masked write at the edge, read data appears L cycles after presentation.
    logic [31:0] mem [WC];
    logic [31:0] rd_pipe [L];
    initial begin
        for (int i = 0; i < WC; i++) mem[i] = 32'hA5A5_0000 | i;
        for (int i = 0; i < L; i++) rd_pipe[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_en && ram_wr)
            for (int b = 0; b < 4; b++)
                if (ram_mask[b]) mem[ram_addr][b*8 +: 8] <= ram_wrData[b*8 +: 8];
        if (ram_en && !ram_wr) rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdData = rd_pipe[L-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one command from a negedge; returns at the negedge after its accept edge.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [3:0] m,
                        input logic [31:0] d);
        int stalls;
        stalls = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_mask = m; cmd_data = d;
        #1;
        while (!cmd_ready && stalls < 50) begin
            @(negedge clk); #1; stalls++;
        end
        checks++;
        if (stalls >= 50) begin
            errors++; $display("FAIL send_accept: addr %0d not accepted within 50 cycles", a);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for the FIFO head, starting at a negedge.
    task automatic wait_rsp(output logic [31:0] d, output bit got);
        got = 1'b0; d = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid) begin got = 1'b1; d = rsp_data; end
            else @(negedge clk);
        end
    endtask

    task automatic pop_one();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int first, nclr, badclr;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rst_ram_wr: got %b want 0", ram_wr); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
        checks++; if (ram_mask !== '0) begin errors++; $display("FAIL rst_ram_mask: got %h want 0", ram_mask); end
        checks++; if (ram_wrData !== '0) begin errors++; $display("FAIL rst_ram_wrData: got %h want 0", ram_wrData); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        reset = 1'b0;
        first = 0; nclr = 0; badclr = 0;
        for (int k = 1; k <= 40 && first == 0; k++) begin
            @(negedge clk);
            if (ram_en && ram_wr) begin
                if (ram_addr !== AW'(nclr) || ram_wrData !== '0 || ram_mask !== 4'hF) badclr++;
                nclr++;
            end
            if (init_done === 1'b1) first = k;
        end
        checks++; if (first != INIT_EDGE) begin errors++; $display("FAIL init_done_edge: got %0d want %0d", first, INIT_EDGE); end
        checks++; if (nclr != NCLR) begin errors++; $display("FAIL clear_writes: got %0d want %0d", nclr, NCLR); end
        checks++; if (badclr != 0) begin errors++; $display("FAIL clear_content: got %0d bad writes want 0", badclr); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_init: got %b want 1", cmd_ready); end
    endtask

`ifdef RAM_INIT_ZEROIZE_EN
    task automatic test_zeroize();
        logic [31:0] d; bit got;
        send(1'b0, 4'd3, 4'h0, 32'h0);
        wait_rsp(d, got);
        checks++; if (!got || d !== 32'h0) begin errors++; $display("FAIL zeroize_addr3: got %h (valid %0d) want 00000000", d, got); end
        pop_one();
        send(1'b0, 4'd15, 4'h0, 32'h0);
        wait_rsp(d, got);
        checks++; if (!got || d !== 32'h0) begin errors++; $display("FAIL zeroize_addr15: got %h (valid %0d) want 00000000", d, got); end
        pop_one();
    endtask
`endif

    task automatic test_write_read();
        send(1'b1, 4'd5, 4'hF, 32'hDEADBEEF);
        checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b1) begin errors++; $display("FAIL wr_present: en %b wr %b want 1 1", ram_en, ram_wr); end
        checks++; if (ram_addr !== 4'd5 || ram_mask !== 4'hF || ram_wrData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_fields: addr %0d mask %h data %h want 5 f deadbeef", ram_addr, ram_mask, ram_wrData); end
        @(negedge clk);
        checks++; if (ram_en !== 1'b0 || ram_wr !== 1'b0) begin errors++; $display("FAIL idle_en: en %b wr %b want 0 0", ram_en, ram_wr); end
        checks++; if (ram_addr !== 4'd5 || ram_wrData !== 32'hDEADBEEF) begin
            errors++; $display("FAIL idle_hold: addr %0d data %h want 5 deadbeef", ram_addr, ram_wrData); end
        send(1'b0, 4'd5, 4'h0, 32'h0);
        checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 4'd5) begin
            errors++; $display("FAIL rd_present: en %b wr %b addr %0d want 1 0 5", ram_en, ram_wr, ram_addr); end
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            if (k == L) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_early: valid %b at edge +%0d want 0", rsp_valid, k); end
            end
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_latency: valid %b at edge +%0d want 1", rsp_valid, L + 1); end
        checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rsp_data_5: got %h want deadbeef", rsp_data); end
        pop_one();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty: valid %b want 0", rsp_valid); end
    endtask

    task automatic test_mask();
        logic [31:0] d; bit got;
        send(1'b1, 4'd7, 4'hF, 32'hFFFFFFFF);
        send(1'b1, 4'd7, 4'h3, 32'h11223344);
        checks++; if (ram_mask !== 4'h3) begin errors++; $display("FAIL mask_present: got %h want 3", ram_mask); end
        send(1'b0, 4'd7, 4'h0, 32'h0);
        wait_rsp(d, got);
        checks++; if (!got || d !== 32'hFFFF3344) begin errors++; $display("FAIL mask_merge: got %h (valid %0d) want ffff3344", d, got); end
        pop_one();
    endtask

    task automatic test_wr_after_rd();
        logic [31:0] d; bit got;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd5; cmd_mask = 4'h0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", cmd_ready); end
        @(posedge clk); @(negedge clk);
        cmd_wr = 1'b1; cmd_addr = 4'd9; cmd_mask = 4'hF; cmd_data = 32'h12345678;
        #1;
        checks++; if (cmd_ready !== ((L == 2) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL wr_block: ready %b want %b", cmd_ready, (L == 2) ? 1'b0 : 1'b1); end
        @(posedge clk); @(negedge clk);
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_unblock: ready %b want 1", cmd_ready); end
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 4'd9) begin
            errors++; $display("FAIL wr_after_rd_present: en %b wr %b addr %0d want 1 1 9", ram_en, ram_wr, ram_addr); end
        wait_rsp(d, got);
        checks++; if (!got || d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_intact: got %h (valid %0d) want deadbeef", d, got); end
        pop_one();
        send(1'b0, 4'd9, 4'h0, 32'h0);
        wait_rsp(d, got);
        checks++; if (!got || d !== 32'h12345678) begin errors++; $display("FAIL wr_landed: got %h (valid %0d) want 12345678", d, got); end
        pop_one();
    endtask

    task automatic test_credit();
        int issued, ngot;
        bit acc;
        logic [31:0] got_d [8];
        for (int i = 0; i < 6; i++) send(1'b1, AW'(i), 4'hF, 32'h100 + i);
        issued = 0; ngot = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cmd_valid = (issued < 6); cmd_wr = 1'b0; cmd_addr = AW'(issued);
            #1;
            acc = cmd_valid && cmd_ready;
            @(posedge clk);
            if (acc) issued++;
        end
        checks++; if (issued != RD) begin errors++; $display("FAIL credit_limit: accepted %0d want %0d", issued, RD); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL credit_fifo_valid: got %b want 1", rsp_valid); end
        for (int c = 0; c < 40 && !(ngot == 6 && issued == 6); c++) begin
            cmd_valid = (issued < 6); cmd_wr = 1'b0; cmd_addr = AW'(issued);
            rsp_ready = 1'b1;
            #1;
            acc = cmd_valid && cmd_ready;
            if (rsp_valid && ngot < 8) begin got_d[ngot] = rsp_data; ngot++; end
            @(posedge clk);
            if (acc) issued++;
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (issued != 6 || ngot != 6) begin errors++; $display("FAIL credit_drain: issued %0d returned %0d want 6 6", issued, ngot); end
        for (int i = 0; i < 6 && i < ngot; i++) begin
            checks++; if (got_d[i] !== 32'h100 + i) begin errors++; $display("FAIL credit_order[%0d]: got %h want %h", i, got_d[i], 32'h100 + i); end
        end
    endtask

    task automatic test_reset_inflight();
        int seen;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd0;
        @(posedge clk); @(negedge clk);
        cmd_addr = 4'd1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: ready %b valid %b init %b want 0 0 0", cmd_ready, rsp_valid, init_done); end
        checks++; if (ram_en !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== '0 || ram_mask !== '0 || ram_wrData !== '0) begin
            errors++; $display("FAIL midrst_ram: en %b wr %b addr %h mask %h data %h want all 0", ram_en, ram_wr, ram_addr, ram_mask, ram_wrData); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_rsp: rsp_valid high %0d cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
`ifdef RAM_INIT_ZEROIZE_EN
        test_zeroize();
`endif
        test_write_read();
        test_mask();
        test_wr_after_rd();
        test_credit();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
